// File: rtl/tc_clk_pkg.sv
// tc_clk_pkg: shared types and constants for the clock-enable divider.
package tc_clk_pkg;
    localparam int DefaultDivWidth = 8;
    localparam int DivMin = 1;
    typedef logic [DefaultDivWidth-1:0] clk_div_t;
endpackage

// File: rtl/tc_clk_en_div_chan.sv
// tc_clk_en_div_chan: one enable channel with a free-running period counter,
// a gate register that only changes at period boundaries, and a ratio handshake.
module tc_clk_en_div_chan
    import tc_clk_pkg::*;
#(
    parameter int DivWidth   = 8,
    parameter int DefaultDiv = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DivWidth-1:0] div,
    input  logic                div_valid,
    output logic                div_ready,
    output logic                strobe
);
    logic [DivWidth-1:0] cnt_q;
    logic [DivWidth-1:0] div_q;
    logic                en_q;
    logic                tick;

    // Ratios 0 and 1 both mean "every cycle".
    assign tick      = (div_q <= DivWidth'(DivMin)) | (cnt_q == div_q - 1'b1);
    assign div_ready = tick;
    assign strobe    = tick & en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DivWidth'(DefaultDiv);
            en_q  <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) en_q <= en;
            if (tick && div_valid) div_q <= div;
        end
    end
endmodule

// File: rtl/tc_clk_en_div.sv
// tc_clk_en_div: multi-channel clock-enable generator; each channel strobes
// once per programmed period, and test_en_i forces every enable high.
module tc_clk_en_div
    import tc_clk_pkg::*;
#(
    parameter int NumChannels = 4,
    parameter int DivWidth    = 8,
    parameter int DefaultDiv  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            test_en_i,
    input  logic [NumChannels-1:0]          en_i,
    input  logic [NumChannels*DivWidth-1:0] div_i,
    input  logic [NumChannels-1:0]          div_valid_i,
    output logic [NumChannels-1:0]          div_ready_o,
    output logic [NumChannels-1:0]          clk_en_o
);
    logic [NumChannels-1:0] strobe;

    for (genvar c = 0; c < NumChannels; c++) begin : gen_chan
        tc_clk_en_div_chan #(
            .DivWidth  (DivWidth),
            .DefaultDiv(DefaultDiv)
        ) u_chan (
            .clk      (clk_i),
            .rst      (rst_i),
            .en       (en_i[c]),
            .div      (div_i[c*DivWidth +: DivWidth]),
            .div_valid(div_valid_i[c]),
            .div_ready(div_ready_o[c]),
            .strobe   (strobe[c])
        );
    end

    assign clk_en_o = strobe | {NumChannels{test_en_i}};
endmodule
